usb_rx_pkt_decoder: RTL and testbench

//  Classifies USB packets from the RX byte stream for bd_controller: drives pckt_rcvd, rcvd_exp_hs, send_nack_in.

---
 rtl/usb_pkg.sv | 48 ++++
 rtl/usb_crc16_chk.sv | 29 ++
 rtl/usb_rx_pkt_decoder.sv | 250 +++++++++++++++++++++++++
 tb/tb_usb_rx_pkt_decoder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared constants for the USB RX packet decoder: PIDs, pckt_rcvd codes, CRC residuals,
// FSM state encodings and the bit-serial CRC helpers.
package usb_pkg;

    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;

    localparam logic [1:0] PCKT_NONE = 2'b00;
    localparam logic [1:0] PCKT_IN   = 2'b01;
    localparam logic [1:0] PCKT_OUT  = 2'b10;
    localparam logic [1:0] PCKT_DATA = 2'b11;

    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    localparam logic [2:0] StWaitIdle = 3'd0;
    localparam logic [2:0] StIdle     = 3'd1;
    localparam logic [2:0] StPid      = 3'd2;
    localparam logic [2:0] StToken    = 3'd3;
    localparam logic [2:0] StData     = 3'd4;
    localparam logic [2:0] StHshake   = 3'd5;
    localparam logic [2:0] StDiscard  = 3'd6;

    // Runs both token bytes (CRC field included) through CRC5; a good token leaves the residual.
    function automatic logic [4:0] crc5_residual(input logic [15:0] bits);
        logic [4:0] crc;
        crc = 5'h1F;
        for (int i = 0; i < 16; i++) begin
            if (bits[i] ^ crc[4]) crc = {crc[3:0], 1'b0} ^ 5'h05;
            else                  crc = {crc[3:0], 1'b0};
        end
        return crc;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] crc;
        crc = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (data[i] ^ crc[15]) crc = {crc[14:0], 1'b0} ^ 16'h8005;
            else                   crc = {crc[14:0], 1'b0};
        end
        return crc;
    endfunction

endpackage

// File: rtl/usb_crc16_chk.sv
// Byte-serial USB CRC16 checker: clear at PID, feed every DATA byte including the CRC,
// ok reports the good-packet residual.
module usb_crc16_chk
    import usb_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] data,
    output logic       ok
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear)   crc_d = 16'hFFFF;
        else if (en) crc_d = crc16_byte(crc_q, data);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) crc_q <= 16'hFFFF;
        else        crc_q <= crc_d;
    end

    assign ok = (crc_q == CRC16_RESIDUAL);

endmodule

// File: rtl/usb_rx_pkt_decoder.sv
// USB RX packet classifier: token/handshake decode and DATA payload forwarding to the RX FIFO.
// Define USB_CRC16_CHECK_EN to verify the DATA CRC16; otherwise CRC bytes are only stripped.
module usb_rx_pkt_decoder
    import usb_pkg::*;
#(
    parameter logic [3:0]  ENDPOINT      = 4'd1,
    parameter int unsigned MAX_PKT_BYTES = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rx_active,
    input  logic [7:0] rx_byte,
    input  logic       rx_byte_valid,
    input  logic       rx_err,
    input  logic [6:0] dev_addr,
    input  logic       rx_exp_hs,
    input  logic       fifo_full,
    output logic [1:0] pckt_rcvd,
    output logic       rcvd_exp_hs,
    output logic       send_nack_in,
    output logic [7:0] rx_data,
    output logic       rx_data_wen,
    output logic       rx_data_commit,
    output logic       rx_data_abort
);

    localparam int unsigned    CntW   = $clog2(MAX_PKT_BYTES + 4);
    localparam logic [CntW-1:0] CntMax = '1;
    localparam logic [CntW-1:0] OvfIdx = CntW'(MAX_PKT_BYTES + 2);

    logic [2:0]      state_q, state_d;
    logic            tok_ok_q, tok_ok_d;
    logic            tok_out_q, tok_out_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      tok_b1_q, tok_b1_d, tok_b2_q, tok_b2_d;
    logic [7:0]      dly0_q, dly0_d, dly1_q, dly1_d;
    logic            wrote_q, wrote_d;
    logic            nack_q, nack_d;
    logic [1:0]      pckt_rcvd_q, pckt_rcvd_d;
    logic            rcvd_exp_hs_q, rcvd_exp_hs_d;
    logic            send_nack_in_q, send_nack_in_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            wen_q, wen_d;
    logic            commit_q, commit_d;
    logic            abort_q, abort_d;

    logic            decode_pid;
    logic            tok_match;
    logic            crc_clear, crc_en, crc_ok;

`ifdef USB_CRC16_CHECK_EN
    usb_crc16_chk u_crc16 (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (crc_clear),
        .en    (crc_en),
        .data  (rx_byte),
        .ok    (crc_ok)
    );
`else
    logic unused_crc;
    assign unused_crc = crc_clear ^ crc_en;
    assign crc_ok     = 1'b1;
`endif

    always_comb begin
        tok_match = (cnt_q == CntW'(2))
                 && (crc5_residual({tok_b2_q, tok_b1_q}) == CRC5_RESIDUAL)
                 && (tok_b1_q[6:0] == dev_addr)
                 && ({tok_b2_q[2:0], tok_b1_q[7]} == ENDPOINT);
    end

    always_comb begin
        state_d        = state_q;
        tok_ok_d       = tok_ok_q;
        tok_out_d      = tok_out_q;
        cnt_d          = cnt_q;
        tok_b1_d       = tok_b1_q;
        tok_b2_d       = tok_b2_q;
        dly0_d         = dly0_q;
        dly1_d         = dly1_q;
        wrote_d        = wrote_q;
        nack_d         = nack_q;
        rx_data_d      = rx_data_q;
        pckt_rcvd_d    = PCKT_NONE;
        rcvd_exp_hs_d  = 1'b0;
        send_nack_in_d = 1'b0;
        wen_d          = 1'b0;
        commit_d       = 1'b0;
        abort_d        = 1'b0;
        decode_pid     = 1'b0;
        crc_clear      = 1'b0;
        crc_en         = 1'b0;

        case (state_q)
            StWaitIdle: if (!rx_active) state_d = StIdle;
            StIdle: begin
                if (rx_active) begin
                    state_d    = StPid;
                    decode_pid = rx_byte_valid;
                end
            end
            StPid: begin
                if (rx_err)             state_d    = StDiscard;
                else if (!rx_active)    state_d    = StIdle;
                else if (rx_byte_valid) decode_pid = 1'b1;
            end
            StToken: begin
                if (rx_err) begin
                    state_d = StDiscard;
                end else if (!rx_active) begin
                    state_d = StIdle;
                    if (tok_match) begin
                        pckt_rcvd_d = tok_out_q ? PCKT_OUT : PCKT_IN;
                        tok_ok_d    = tok_out_q;
                    end else begin
                        tok_ok_d = 1'b0;
                    end
                end else if (rx_byte_valid) begin
                    if (cnt_q == '0) begin
                        tok_b1_d = rx_byte;
                        cnt_d    = CntW'(1);
                    end else if (cnt_q == CntW'(1)) begin
                        tok_b2_d = rx_byte;
                        cnt_d    = CntW'(2);
                    end else begin
                        tok_ok_d = 1'b0;
                        state_d  = StDiscard;
                    end
                end
            end
            StData: begin
                if (rx_err) begin
                    state_d = StDiscard;
                    abort_d = wrote_q;
                end else if (!rx_active) begin
                    state_d = StIdle;
                    if (nack_q) begin
                        send_nack_in_d = 1'b1;
                    end else if (cnt_q >= CntW'(2) && crc_ok) begin
                        commit_d    = 1'b1;
                        pckt_rcvd_d = PCKT_DATA;
                        tok_ok_d    = 1'b0;
                    end else begin
                        abort_d = 1'b1;
                    end
                end else if (rx_byte_valid) begin
                    // Two-byte delay line keeps the trailing CRC16 out of the FIFO.
                    crc_en = 1'b1;
                    dly1_d = rx_byte;
                    dly0_d = dly1_q;
                    cnt_d  = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
                    if (!nack_q && cnt_q >= CntW'(2)) begin
                        if (cnt_q == OvfIdx) begin
                            abort_d = 1'b1;
                            state_d = StDiscard;
                        end else begin
                            wen_d     = 1'b1;
                            rx_data_d = dly0_q;
                            wrote_d   = 1'b1;
                        end
                    end
                end
            end
            StHshake: begin
                if (rx_err) begin
                    state_d = StDiscard;
                end else if (!rx_active) begin
                    state_d       = StIdle;
                    rcvd_exp_hs_d = rx_exp_hs;
                end else if (rx_byte_valid) begin
                    state_d = StDiscard;
                end
            end
            StDiscard: if (!rx_active) state_d = StIdle;
            default:   state_d = StWaitIdle;
        endcase

        if (decode_pid) begin
            cnt_d     = '0;
            wrote_d   = 1'b0;
            crc_clear = 1'b1;
            if (rx_byte[7:4] != ~rx_byte[3:0]) begin
                state_d = StDiscard;
            end else begin
                case (rx_byte)
                    PID_OUT, PID_IN: begin
                        state_d   = StToken;
                        tok_out_d = (rx_byte == PID_OUT);
                    end
                    PID_DATA0, PID_DATA1: begin
                        state_d = tok_ok_q ? StData : StDiscard;
                        nack_d  = fifo_full;
                    end
                    PID_ACK: state_d = StHshake;
                    default: state_d = StDiscard;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q        <= StWaitIdle;
            tok_ok_q       <= 1'b0;
            tok_out_q      <= 1'b0;
            cnt_q          <= '0;
            tok_b1_q       <= 8'h00;
            tok_b2_q       <= 8'h00;
            dly0_q         <= 8'h00;
            dly1_q         <= 8'h00;
            wrote_q        <= 1'b0;
            nack_q         <= 1'b0;
            pckt_rcvd_q    <= PCKT_NONE;
            rcvd_exp_hs_q  <= 1'b0;
            send_nack_in_q <= 1'b0;
            rx_data_q      <= 8'h00;
            wen_q          <= 1'b0;
            commit_q       <= 1'b0;
            abort_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            tok_ok_q       <= tok_ok_d;
            tok_out_q      <= tok_out_d;
            cnt_q          <= cnt_d;
            tok_b1_q       <= tok_b1_d;
            tok_b2_q       <= tok_b2_d;
            dly0_q         <= dly0_d;
            dly1_q         <= dly1_d;
            wrote_q        <= wrote_d;
            nack_q         <= nack_d;
            pckt_rcvd_q    <= pckt_rcvd_d;
            rcvd_exp_hs_q  <= rcvd_exp_hs_d;
            send_nack_in_q <= send_nack_in_d;
            rx_data_q      <= rx_data_d;
            wen_q          <= wen_d;
            commit_q       <= commit_d;
            abort_q        <= abort_d;
        end
    end

    assign pckt_rcvd      = pckt_rcvd_q;
    assign rcvd_exp_hs    = rcvd_exp_hs_q;
    assign send_nack_in   = send_nack_in_q;
    assign rx_data        = rx_data_q;
    assign rx_data_wen    = wen_q;
    assign rx_data_commit = commit_q;
    assign rx_data_abort  = abort_q;

endmodule

// File: tb/tb_usb_rx_pkt_decoder.sv
// Bench for usb_rx_pkt_decoder: packet-level reference model schedules expected outputs per
// cycle; one compare process checks every cycle, plus literal checks on logged DUT activity.
module tb_usb_rx_pkt_decoder;

    localparam int MAX = 64;

    typedef struct packed {
        logic [1:0] pckt;
        logic       hs;
        logic       nack;
        logic       wen;
        logic [7:0] data;
        logic       commit;
        logic       abort;
    } out_t;

    logic       clk, n_rst, rx_active, rx_byte_valid, rx_err, rx_exp_hs, fifo_full;
    logic [7:0] rx_byte, rx_data;
    logic [6:0] dev_addr;
    logic [1:0] pckt_rcvd;
    logic       rcvd_exp_hs, send_nack_in, rx_data_wen, rx_data_commit, rx_data_abort;

    usb_rx_pkt_decoder #(.ENDPOINT(4'd1), .MAX_PKT_BYTES(MAX)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .rx_active      (rx_active),
        .rx_byte        (rx_byte),
        .rx_byte_valid  (rx_byte_valid),
        .rx_err         (rx_err),
        .dev_addr       (dev_addr),
        .rx_exp_hs      (rx_exp_hs),
        .fifo_full      (fifo_full),
        .pckt_rcvd      (pckt_rcvd),
        .rcvd_exp_hs    (rcvd_exp_hs),
        .send_nack_in   (send_nack_in),
        .rx_data        (rx_data),
        .rx_data_wen    (rx_data_wen),
        .rx_data_commit (rx_data_commit),
        .rx_data_abort  (rx_data_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    out_t       exp_tab [int];
    logic [7:0] pkt [$];
    logic [7:0] wr_log [$];
    logic [1:0] pk_log [$];
    bit         tok_ok_m;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        out_t e;
        out_t a;
        e = exp_tab.exists(cyc) ? exp_tab[cyc] : '0;
        a = {pckt_rcvd, rcvd_exp_hs, send_nack_in, rx_data_wen, rx_data, rx_data_commit,
             rx_data_abort};
        if (a.wen !== 1'b1) a.data = 8'h00;
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL outputs @cyc %0d: got pckt=%b hs=%b nack=%b wen=%b data=%h commit=%b abort=%b, required pckt=%b hs=%b nack=%b wen=%b data=%h commit=%b abort=%b",
                     cyc, a.pckt, a.hs, a.nack, a.wen, a.data, a.commit, a.abort,
                     e.pckt, e.hs, e.nack, e.wen, e.data, e.commit, e.abort);
        end
        if (rx_data_wen === 1'b1) wr_log.push_back(rx_data);
        if (pckt_rcvd !== 2'b00) pk_log.push_back(pckt_rcvd);
    end

    task automatic chk(input string name, input int got, input int expv);
        n_cmp++;
        if (got != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, expv, expv);
        end
    endtask

    // Second token byte {CRC5, endp[3:1]} from the field values.
    function automatic logic [7:0] tok_b2(input logic [6:0] a, input logic [3:0] ep);
        logic [10:0] d;
        logic [4:0]  c;
        d = {ep, a};
        c = 5'h1F;
        for (int i = 0; i < 11; i++)
            c = {c[3:0], 1'b0} ^ ((d[i] ^ c[4]) ? 5'h05 : 5'h00);
        c = ~c;
        return {c[0], c[1], c[2], c[3], c[4], ep[3:1]};
    endfunction

    // CRC16 wire bytes {first, second} over pkt[lo..hi].
    function automatic logic [15:0] crc16_of(input int lo, input int hi);
        logic [15:0] c;
        logic [7:0]  b0, b1;
        c = 16'hFFFF;
        for (int k = lo; k <= hi; k++)
            for (int i = 0; i < 8; i++)
                c = {c[14:0], 1'b0} ^ ((pkt[k][i] ^ c[15]) ? 16'h8005 : 16'h0000);
        c = ~c;
        for (int i = 0; i < 8; i++) begin
            b0[i] = c[15-i];
            b1[i] = c[7-i];
        end
        return {b0, b1};
    endfunction

    task automatic mk_tok(input logic [7:0] pid, input logic [6:0] a, input logic [3:0] ep);
        pkt = {};
        pkt.push_back(pid);
        pkt.push_back({ep[0], a});
        pkt.push_back(tok_b2(a, ep));
    endtask

    task automatic mk_data(input logic [7:0] pid, input int len, input logic [7:0] base);
        logic [15:0] cb;
        pkt = {};
        pkt.push_back(pid);
        for (int i = 0; i < len; i++) pkt.push_back(base + 8'(i));
        cb = crc16_of(1, len);
        pkt.push_back(cb[15:8]);
        pkt.push_back(cb[7:0]);
    endtask

    // Predicts the packet's outputs, then drives it; err_idx >= 0 replaces that byte with rx_err.
    task automatic run_pkt(input int err_idx);
        out_t        at_b [0:127];
        out_t        at_err, at_eop;
        int          n, lim, nd, wrote;
        bit          aborted, crc_ok;
        logic [7:0]  pid;
        logic [6:0]  a;
        logic [3:0]  ep;
        logic [15:0] cb;
        n   = pkt.size();
        lim = (err_idx >= 0) ? err_idx : n;
        for (int i = 0; i < 128; i++) at_b[i] = '0;
        at_err = '0;
        at_eop = '0;
        if (lim > 0) begin
            pid = pkt[0];
            if (pid == 8'hE1 || pid == 8'h69) begin
                if (err_idx < 0) begin
                    if (n == 3) begin
                        a  = pkt[1][6:0];
                        ep = {pkt[2][2:0], pkt[1][7]};
                        if (pkt[2] == tok_b2(a, ep) && a == dev_addr && ep == 4'd1) begin
                            at_eop.pckt = (pid == 8'hE1) ? 2'b10 : 2'b01;
                            tok_ok_m    = (pid == 8'hE1);
                        end else begin
                            tok_ok_m = 1'b0;
                        end
                    end else begin
                        tok_ok_m = 1'b0;
                    end
                end
            end else if ((pid == 8'hC3 || pid == 8'h4B) && tok_ok_m) begin
                if (fifo_full) begin
                    if (err_idx < 0) at_eop.nack = 1'b1;
                end else begin
                    nd      = lim - 1;
                    aborted = 1'b0;
                    wrote   = 0;
                    for (int k = 2; k < nd && !aborted; k++) begin
                        if (k - 2 == MAX) begin
                            at_b[k+1].abort = 1'b1;
                            aborted         = 1'b1;
                        end else begin
                            at_b[k+1].wen  = 1'b1;
                            at_b[k+1].data = pkt[k-1];
                            wrote++;
                        end
                    end
                    if (!aborted && err_idx >= 0) begin
                        at_err.abort = (wrote > 0);
                    end else if (!aborted) begin
                        crc_ok = (nd >= 2);
`ifdef USB_CRC16_CHECK_EN
                        if (nd >= 2) begin
                            cb     = crc16_of(1, n - 3);
                            crc_ok = (cb == {pkt[n-2], pkt[n-1]});
                        end
`endif
                        if (crc_ok) begin
                            at_eop.commit = 1'b1;
                            at_eop.pckt   = 2'b11;
                            tok_ok_m      = 1'b0;
                        end else begin
                            at_eop.abort = 1'b1;
                        end
                    end
                end
            end else if (pid == 8'hD2) begin
                if (err_idx < 0 && n == 1 && rx_exp_hs) at_eop.hs = 1'b1;
            end
        end

        @(posedge clk); #1;
        rx_active = 1'b1;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk); #1;
            rx_byte          = pkt[i];
            rx_byte_valid    = 1'b1;
            exp_tab[cyc + 1] = at_b[i];
        end
        if (err_idx >= 0) begin
            @(posedge clk); #1;
            rx_byte_valid    = 1'b0;
            rx_err           = 1'b1;
            exp_tab[cyc + 1] = at_err;
            @(posedge clk); #1;
            rx_err = 1'b0;
        end
        @(posedge clk); #1;
        rx_byte_valid    = 1'b0;
        rx_active        = 1'b0;
        exp_tab[cyc + 1] = at_eop;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_byte       = b;
        rx_byte_valid = 1'b1;
    endtask

    initial begin
        logic [15:0] cb;
        n_rst = 1'b0; rx_active = 1'b0; rx_byte = 8'h00; rx_byte_valid = 1'b0;
        rx_err = 1'b0; rx_exp_hs = 1'b0; fifo_full = 1'b0; dev_addr = 7'h05;
        tok_ok_m = 1'b0;
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        chk("crc5_model_pin", int'(tok_b2(7'h00, 4'h0)), 8'h10);
        pkt = {};
        cb  = crc16_of(1, 0);
        chk("crc16_model_pin", int'(cb), 16'h0000);

        // IN token, good
        pk_log = {};
        mk_tok(8'h69, 7'h05, 4'd1); run_pkt(-1);
        chk("in_tok_pckt_count", pk_log.size(), 1);
        if (pk_log.size() > 0) chk("in_tok_pckt_code", int'(pk_log[0]), 1);

        // Wrong address, flipped CRC5 bit, wrong endpoint, then DATA must be refused
        mk_tok(8'hE1, 7'h05, 4'd1); run_pkt(-1);
        mk_tok(8'h69, 7'h06, 4'd1); run_pkt(-1);
        mk_tok(8'h69, 7'h05, 4'd1); pkt[2] = pkt[2] ^ 8'h08; run_pkt(-1);
        mk_tok(8'h69, 7'h05, 4'd2); run_pkt(-1);
        mk_data(8'hC3, 3, 8'h10); run_pkt(-1);

        // OUT + DATA0 01..04
        mk_tok(8'hE1, 7'h05, 4'd1); run_pkt(-1);
        wr_log = {}; pk_log = {};
        mk_data(8'hC3, 4, 8'h01); run_pkt(-1);
        chk("data_wen_count", wr_log.size(), 4);
        for (int i = 0; i < 4 && i < wr_log.size(); i++)
            chk($sformatf("data_byte%0d", i), int'(wr_log[i]), i + 1);
        chk("data_pckt_count", pk_log.size(), 1);
        if (pk_log.size() > 0) chk("data_pckt_code", int'(pk_log[0]), 3);

        // OUT + DATA1 with corrupted CRC
        mk_tok(8'hE1, 7'h05, 4'd1); run_pkt(-1);
        mk_data(8'h4B, 5, 8'h30); pkt[7] = pkt[7] ^ 8'h01; run_pkt(-1);

        // OUT + DATA0 with fifo_full
        mk_tok(8'hE1, 7'h05, 4'd1); run_pkt(-1);
        fifo_full = 1'b1; wr_log = {};
        mk_data(8'hC3, 4, 8'h01); run_pkt(-1);
        fifo_full = 1'b0;
        chk("nack_no_writes", wr_log.size(), 0);

        // Zero-length DATA and too-short DATA
        mk_tok(8'hE1, 7'h05, 4'd1); run_pkt(-1);
        mk_data(8'hC3, 0, 8'h00); run_pkt(-1);
        mk_tok(8'hE1, 7'h05, 4'd1); run_pkt(-1);
        pkt = {8'hC3, 8'h00}; run_pkt(-1);
        mk_data(8'h4B, 2, 8'h55); run_pkt(-1);

        // IN clears the OUT permission
        mk_tok(8'hE1, 7'h05, 4'd1); run_pkt(-1);
        mk_tok(8'h69, 7'h05, 4'd1); run_pkt(-1);
        mk_data(8'hC3, 2, 8'h40); run_pkt(-1);

        // Handshakes
        rx_exp_hs = 1'b1; pkt = {8'hD2}; run_pkt(-1);
        rx_exp_hs = 1'b0; pkt = {8'hD2}; run_pkt(-1);
        rx_exp_hs = 1'b1; pkt = {8'hD2, 8'h00}; run_pkt(-1);
        rx_exp_hs = 1'b0;

        // Overflow at MAX+1 payload bytes, then exactly MAX
        mk_tok(8'hE1, 7'h05, 4'd1); run_pkt(-1);
        wr_log = {};
        mk_data(8'hC3, MAX + 1, 8'h80); run_pkt(-1);
        chk("ovf_wen_count", wr_log.size(), MAX);
        mk_data(8'hC3, MAX, 8'h20); run_pkt(-1);

        // rx_err mid-DATA after two writes
        mk_tok(8'hE1, 7'h05, 4'd1); run_pkt(-1);
        mk_data(8'hC3, 6, 8'hA0); run_pkt(5);

        // Bad PID and EOP without PID
        pkt = {8'h12, 8'h34, 8'h56}; run_pkt(-1);
        pkt = {}; run_pkt(-1);

        // Reset mid-DATA; the trailing ACK-looking byte must not be decoded
        mk_tok(8'hE1, 7'h05, 4'd1); run_pkt(-1);
        @(posedge clk); #1 rx_active = 1'b1;
        drive_byte(8'hC3);
        drive_byte(8'h01);
        drive_byte(8'h02);
        drive_byte(8'h03);
        exp_tab[cyc + 1] = '{pckt: 2'b00, hs: 1'b0, nack: 1'b0, wen: 1'b1, data: 8'h01,
                             commit: 1'b0, abort: 1'b0};
        @(posedge clk); #1 rx_byte_valid = 1'b0; n_rst = 1'b0;
        @(posedge clk); #1 n_rst = 1'b1; tok_ok_m = 1'b0;
        rx_exp_hs = 1'b1;
        drive_byte(8'hD2);
        @(posedge clk); #1 rx_byte_valid = 1'b0; rx_active = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx_exp_hs = 1'b0;

        // Recovery after reset
        mk_tok(8'hE1, 7'h05, 4'd1); run_pkt(-1);
        mk_data(8'hC3, 3, 8'h61); run_pkt(-1);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
